// File: rtl/rob_tag_fifo.sv
// rob_tag_fifo
// Free-list allocator for the in-flight tags that dispatch writes into the
// register status table. Dispatch pops the head free tag. Commit pushes
// retired tags back. A mispredict flush reclaims every outstanding tag in a
// single cycle.
//
// Ports:
//   clk             - clock; all state updates on the rising edge
//   rst             - synchronous active-high reset; refills the list with 0..DEPTH-1
//   tagpop_dispatch - dispatch consumes tagout_tf this cycle
//   tagpush_commit  - commit returns tagin_commit this cycle
//   tagin_commit    - tag being freed
//   flush_tf        - mispredict recovery; frees all outstanding tags
//   tagout_tf       - head free tag (first-word fall-through)
//   tagempty_tf     - no free tag; dispatch must stall
//   tagfull_tf      - all DEPTH tags are free
//   count_tf        - number of free tags, 0..DEPTH
//   err_tf          - sticky protocol-error flag, cleared only by rst
module rob_tag_fifo #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tagpop_dispatch,
  input  logic             tagpush_commit,
  input  logic [TAG_W-1:0] tagin_commit,
  input  logic             flush_tf,
  output logic [TAG_W-1:0] tagout_tf,
  output logic             tagempty_tf,
  output logic             tagfull_tf,
  output logic [TAG_W:0]   count_tf,
  output logic             err_tf
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [TAG_W:0]   rd_ptr;
  logic [TAG_W:0]   wr_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             proto_err;

  // Occupancy comes from the pointer difference. The extra wrap bit tells
  // full apart from empty when the indices are equal.
  always_comb begin
    count_tf    = wr_ptr - rd_ptr;
    tagempty_tf = (count_tf == '0);
    tagfull_tf  = (count_tf == DEPTH_CNT);
    tagout_tf   = mem[rd_ptr[TAG_W-1:0]];
  end

  // Accept or reject the requests for this cycle. A push into a full list is
  // legal only when a pop frees a slot in the same cycle. A pop from an empty
  // list is always rejected, even when a push arrives alongside it, because
  // the pushed tag is not readable until the next cycle. Flush takes
  // precedence, so neither request is accepted or flagged during a flush.
  always_comb begin
    pop_ok    = 1'b0;
    push_ok   = 1'b0;
    proto_err = 1'b0;
    if (!flush_tf) begin
      pop_ok    = tagpop_dispatch && !tagempty_tf;
      push_ok   = tagpush_commit && (!tagfull_tf || tagpop_dispatch);
      proto_err = (tagpop_dispatch && tagempty_tf) ||
                  (tagpush_commit && tagfull_tf && !tagpop_dispatch);
    end
  end

  // Pointer and error-flag state. On a flush the read pointer moves one full
  // lap behind the write pointer. The outstanding tags are still stored
  // between the two pointers in allocation order, so they all become free
  // again and no data has to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= DEPTH_CNT;
      err_tf <= 1'b0;
    end else if (flush_tf) begin
      rd_ptr <= wr_ptr - DEPTH_CNT;
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (proto_err) begin
        err_tf <= 1'b1;
      end
    end
  end

  // Tag storage. Reset loads every slot with its own index, which makes the
  // whole tag space free. When the list is full, a push paired with a pop
  // writes into the slot the pop is vacating, and that is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(i);
      end
    end else if (push_ok) begin
      mem[wr_ptr[TAG_W-1:0]] <= tagin_commit;
    end
  end

endmodule

// File: doc/rob_tag_fifo.md
Name: rob_tag_fifo

Overview:
- Free-list allocator for the 6-bit in-flight tags written into the register status table at dispatch.
- Dispatch pops one free tag per cycle for the destination register. The {valid, tag} pair then goes to the RST write port.
- Commit pushes each retired tag back to the free list.
- A branch-mispredict flush returns every outstanding tag in one cycle.
- Sits between commit and dispatch, directly upstream of the RST write path.

Parameters:
- TAG_W, 6, tag width. It must match the RST tag fields.
- DEPTH, 64, number of tags. Must equal 2**TAG_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tagpop_dispatch  in  1  dispatch consumes tagout_tf this cycle.
- tagpush_commit  in  1  commit returns tagin_commit this cycle.
- tagin_commit  in  TAG_W  tag being freed.
- flush_tf  in  1  mispredict recovery; frees all outstanding tags.
- tagout_tf  out  TAG_W  head free tag (first-word fall-through).
- tagempty_tf  out  1  no free tag; dispatch must stall.
- tagfull_tf  out  1  all DEPTH tags are free.
- count_tf  out  TAG_W+1  number of free tags, 0..DEPTH.
- err_tf  out  1  sticky protocol-error flag.

Behaviour:
- Storage: DEPTH x TAG_W entry array.
- Pointers: rd_ptr and wr_ptr, each TAG_W+1 bits, where the MSB is the wrap bit. Index = low TAG_W bits.
- count_tf = wr_ptr - rd_ptr, computed modulo 2**(TAG_W+1).
- Flags: tagempty_tf = (count_tf == 0); tagfull_tf = (count_tf == DEPTH).
- tagout_tf = mem[rd_ptr index], a combinational read.
- Reset (rst=1 at a clock edge):
  - mem[i] <= i for all i.
  - rd_ptr <= 0; wr_ptr <= DEPTH, i.e. wrap bit set, index 0.
  - err_tf <= 0.
  - Resulting outputs: count_tf=64, tagfull_tf=1, tagempty_tf=0, tagout_tf=0.
  - rst overrides flush, push and pop.
- Pop (tagpop_dispatch=1 and not empty): rd_ptr <= rd_ptr+1. The new head appears on tagout_tf the next cycle.
- Pop while empty: ignored, pointers unchanged, err_tf <= 1. Exception: if a push is accepted in the same cycle, the pop is still ignored.
- Push (tagpush_commit=1): mem[wr_ptr index] <= tagin_commit; wr_ptr <= wr_ptr+1.
  - Full with no simultaneous pop: push ignored, err_tf <= 1.
  - Full with a simultaneous pop: both are accepted and count stays 64.
- Simultaneous push and pop, not empty and not full: both are accepted and count is unchanged.
- Simultaneous push and pop when empty: the pop is rejected with err_tf set, the push is accepted, and count becomes 1.
- Flush (flush_tf=1, rst=0):
  - rd_ptr <= wr_ptr - DEPTH, i.e. the index is kept and the wrap bit is inverted. Memory is untouched.
  - Next cycle: count_tf=64 and tagfull_tf=1.
  - Flush has priority over push and pop in the same cycle; both are ignored and err_tf is not set.
  - This is correct because outstanding tags still sit in the slots between wr_ptr and rd_ptr, in allocation order.
  - The new tagout_tf is mem[wr_ptr index], the oldest outstanding tag.
- Pointer wrap: both pointers wrap naturally at 2**(TAG_W+1).
- No duplicate-tag check is made on push; supplying unique tags is commit's responsibility.
- err_tf clears only on rst.

Test Plan:
- Reset, then 64 consecutive pops -> tagout_tf reads 0,1,...,63 on successive cycles. After the last pop, count_tf=0 and tagempty_tf=1. A 65th pop sets err_tf=1 with pointers unchanged.
- From reset, pop 3 (tags 0,1,2), then push 1 then 0 -> count_tf=63. After popping to the end, the last entries delivered after tag 63 are 1 then 0.
- Full state with push and pop in the same cycle, pushing tag 5 while head=0 -> count_tf stays 64, err_tf=0, tagout_tf=1 next cycle.
- Empty state with push(tag 9) and pop in the same cycle -> err_tf=1, count_tf=1, tagout_tf=9 next cycle.
- Pop 10 tags, push back tags 0..3, then flush with push asserted in the same cycle -> next cycle count_tf=64, tagfull_tf=1, tagout_tf=4, err_tf=0.
- Assert rst mid-sequence while count_tf=17 and pop is asserted -> next cycle count_tf=64, tagout_tf=0, err_tf=0.
